// File: rtl/image_burster.sv
// Ping-pong image buffer: absorbs a gapped input stream and replays each
// complete image as one contiguous burst of 2^LOG2_IMG_SIZE words.
module image_burster #(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int GAP           = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [NO_CH-1:0] data_in  [THROUGHPUT-1:0],
  output logic             rdy_out,
  output logic             vld_out,
  output logic [NO_CH-1:0] data_out [THROUGHPUT-1:0],
  output logic             last_out
);

  localparam int         W       = NO_CH * THROUGHPUT;
  localparam int         DEPTH   = 1 << LOG2_IMG_SIZE;
  localparam logic [1:0] GAP_CYC = 2'(GAP);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} buf_state_t;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

  buf_state_t               buf_state [2];
  rd_state_t                rd_state;
  logic                     wr_sel;
  logic                     rd_sel;
  logic                     rel_pend;
  logic [LOG2_IMG_SIZE-1:0] wr_cntr;
  logic [LOG2_IMG_SIZE-1:0] rd_cntr;
  logic [1:0]               gap_cntr;
  logic [W-1:0]             mem [2][DEPTH];
  logic [W-1:0]             wr_word;
  logic [W-1:0]             rd_word;
  logic                     wr_en;
  logic                     rd_start;
  logic                     rd_issue;
  logic                     rd_final;

  always_comb begin
    wr_word = '0;
    for (int unsigned i = 0; i < THROUGHPUT; i++)
      wr_word[i*NO_CH +: NO_CH] = data_in[i];
  end

  always_comb begin
    for (int unsigned i = 0; i < THROUGHPUT; i++)
      data_out[i] = rd_word[i*NO_CH +: NO_CH];
  end

  assign rdy_out  = !rst && (buf_state[wr_sel] == EMPTY || buf_state[wr_sel] == FILLING);
  assign wr_en    = vld_in && rdy_out;
  assign rd_start = (rd_state == RD_IDLE) && (buf_state[rd_sel] == FULL) && (gap_cntr == 2'd0);
  assign rd_issue = !rst && ((rd_state == RD_BURST) || rd_start);
  assign rd_final = &rd_cntr;

  // Buffer storage and output word register are left unreset; rd_word only
  // changes on an issued read, so data_out holds while vld_out is low.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_sel][wr_cntr] <= wr_word;
    if (rd_issue)
      rd_word <= mem[rd_sel][rd_cntr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state[0] <= EMPTY;
      buf_state[1] <= EMPTY;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      wr_cntr      <= '0;
      rd_cntr      <= '0;
      rd_state     <= RD_IDLE;
      gap_cntr     <= '0;
      rel_pend     <= 1'b0;
      vld_out      <= 1'b0;
      last_out     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cntr <= wr_cntr + 1'b1;
        if (&wr_cntr) begin
          buf_state[wr_sel] <= FULL;
          wr_sel            <= ~wr_sel;
        end else begin
          buf_state[wr_sel] <= FILLING;
        end
      end

      // rd_sel already points at the next buffer, so the drained one is ~rd_sel;
      // releasing it one edge late keeps it unwritable while its last word is out.
      rel_pend <= 1'b0;
      if (rel_pend)
        buf_state[~rd_sel] <= EMPTY;

      vld_out  <= rd_issue;
      last_out <= rd_issue && rd_final;

      if (rd_issue) begin
        if (rd_start)
          buf_state[rd_sel] <= DRAINING;
        if (rd_final) begin
          rd_cntr  <= '0;
          rd_state <= RD_IDLE;
          rd_sel   <= ~rd_sel;
          rel_pend <= 1'b1;
          gap_cntr <= GAP_CYC;
        end else begin
          rd_cntr  <= rd_cntr + 1'b1;
          rd_state <= RD_BURST;
        end
      end else if (gap_cntr != 2'd0) begin
        gap_cntr <= gap_cntr - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_burster.sv
// Directed bench for image_burster with 8-word images of two 2-bit samples;
// a second instance with GAP=2 covers the inter-burst idle spacing.
module tb_image_burster;

  localparam int NC   = 2;
  localparam int TP   = 2;
  localparam int LG   = 3;
  localparam int NCYC = 140;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld_in = 1'b0;
  logic [NC-1:0] data_in   [TP-1:0];
  logic          rdy_out, vld_out, last_out;
  logic [NC-1:0] data_out  [TP-1:0];
  logic          rdy2, vld2, last2;
  logic [NC-1:0] data2     [TP-1:0];

  always #5 clk = ~clk;

  image_burster #(.NO_CH(NC), .LOG2_IMG_SIZE(LG), .THROUGHPUT(TP), .GAP(0)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .rdy_out(rdy_out), .vld_out(vld_out), .data_out(data_out), .last_out(last_out)
  );

  image_burster #(.NO_CH(NC), .LOG2_IMG_SIZE(LG), .THROUGHPUT(TP), .GAP(2)) dut_gap (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .rdy_out(rdy2), .vld_out(vld2), .data_out(data2), .last_out(last2)
  );

  int errors = 0;
  int checks = 0;

  logic       v [2][NCYC];
  logic       l [2][NCYC];
  logic       r [2][NCYC];
  logic [3:0] d [2][NCYC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    vld_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", vld_out, 0);
    check("rst_last", last_out, 0);
    check("rst_rdy", rdy_out, 0);
    check("rst_vld_gap", vld2, 0);
    check("rst_rdy_gap", rdy2, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle k of a run starts just after the edge that follows reset release;
  // a word offered in cycle k is counted only if rdy_out was high then.
  task automatic run(input int mode, input int limit, input int ncyc);
    int sent;
    sent = 0;
    for (int k = 0; k < ncyc; k++) begin
      logic want;
      case (mode)
        0:       want = 1'b1;
        1:       want = (k % 3 == 0);
        2:       want = (k < 5) || (k >= 105);
        3:       want = (k < 8) || (k >= 20);
        default: want = 1'b0;
      endcase
      rst        = (mode == 3) && (k == 13);
      vld_in     = want && (sent < limit);
      data_in[0] = sent[1:0];
      data_in[1] = sent[3:2];
      @(negedge clk);
      v[0][k] = vld_out; l[0][k] = last_out; r[0][k] = rdy_out; d[0][k] = {data_out[1], data_out[0]};
      v[1][k] = vld2;    l[1][k] = last2;    r[1][k] = rdy2;    d[1][k] = {data2[1], data2[0]};
      if (vld_in && rdy_out) sent++;
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    vld_in = 1'b0;
  endtask

  task automatic scan(input string tag, input int u, input int lo, input int hi, input int base,
                      input int exp_n, input int exp_first, input int exp_last);
    int n, first, lastc;
    n = 0; first = -1; lastc = -1;
    for (int c = lo; c <= hi; c++) begin
      if (v[u][c]) begin
        if (first < 0) first = c;
        check({tag, "_data"}, d[u][c], (base + n) % 16);
        check({tag, "_last"}, l[u][c], (n % 8 == 7));
        n++;
        lastc = c;
      end else begin
        check({tag, "_idle_last"}, l[u][c], 0);
      end
    end
    check({tag, "_count"}, n, exp_n);
    check({tag, "_first"}, first, exp_first);
    check({tag, "_lastcyc"}, lastc, exp_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    data_in[0] = '0;
    data_in[1] = '0;

    do_reset();
    run(0, 8, 40);
    check("contig_rdy0", r[0][0], 1);
    scan("contig", 0, 0, 39, 0, 8, 9, 16);

    do_reset();
    run(1, 8, 50);
    scan("gapped", 0, 0, 49, 0, 8, 23, 30);

    do_reset();
    run(0, 24, 50);
    scan("bp", 0, 0, 49, 0, 24, 9, 33);
    check("bp_rdy15", r[0][15], 1);
    check("bp_rdy16", r[0][16], 0);
    check("bp_rdy17", r[0][17], 1);
    check("bp_cont17", v[0][17], 1);
    check("bp_idle25", v[0][25], 0);

    do_reset();
    run(0, 16, 40);
    scan("gap2", 1, 0, 39, 0, 16, 9, 26);
    check("gap2_last16", l[1][16], 1);
    check("gap2_idle17", v[1][17], 0);
    check("gap2_idle18", v[1][18], 0);
    check("gap2_start19", v[1][19], 1);

    do_reset();
    run(3, 16, 60);
    scan("mid_a", 0, 0, 13, 0, 5, 9, 13);
    check("mid_rdy14", r[0][14], 1);
    scan("mid_b", 0, 14, 59, 8, 8, 29, 36);

    do_reset();
    run(2, 8, 130);
    scan("partial", 0, 0, 129, 0, 8, 109, 116);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_burster.md
IMAGE_BURSTER -- requirements
Module: image_burster

Interface
REQ-001 Parameter NO_CH, default 2: bits per sample.
REQ-002 Parameter LOG2_IMG_SIZE, default 10: image length is 2^LOG2_IMG_SIZE words.
REQ-003 Parameter THROUGHPUT, default 1: samples per word, power of 2.
REQ-004 Parameter GAP, default 0, range 0..3: minimum idle cycles between consecutive output bursts.
REQ-005 clk  input  1: clock; all logic on rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 vld_in  input  1: input word valid; may be gapped arbitrarily.
REQ-008 data_in  input  NO_CH x THROUGHPUT (unpacked [THROUGHPUT-1:0]): input word.
REQ-009 rdy_out  output  1: block accepts a word this cycle.
REQ-010 vld_out  output  1: output word valid, registered.
REQ-011 data_out  output  NO_CH x THROUGHPUT (unpacked [THROUGHPUT-1:0]): output word, registered.
REQ-012 last_out  output  1: high with the final word of each burst, registered.

Function
REQ-013 Block SHALL convert a gapped input stream into contiguous image bursts: once vld_out rises, it SHALL stay high for exactly 2^LOG2_IMG_SIZE consecutive cycles.
REQ-014 Storage SHALL be two image buffers (ping-pong), each 2^LOG2_IMG_SIZE words, with write select wr_sel and read select rd_sel.
REQ-015 Each buffer SHALL have state EMPTY, FILLING, FULL or DRAINING.
REQ-016 Input handshake: a word is accepted iff vld_in && rdy_out; vld_in while rdy_out low SHALL be ignored and data dropped.
REQ-017 rdy_out SHALL be high iff rst is low and buffer[wr_sel] is EMPTY or FILLING (combinational from registered state).
REQ-018 Accept into an EMPTY buffer SHALL move it to FILLING and write address 0.
REQ-019 Each accept SHALL write address wr_cntr, then increment wr_cntr modulo 2^LOG2_IMG_SIZE.
REQ-020 Accept at wr_cntr = 2^LOG2_IMG_SIZE-1 SHALL set that buffer FULL, wrap wr_cntr to 0 and toggle wr_sel in the same edge.
REQ-021 Read side SHALL be idle or bursting; when idle, GAP idle cycles have elapsed since the previous last_out (or since reset), and buffer[rd_sel] is FULL, it SHALL set the buffer DRAINING and issue read address 0.
REQ-022 Read address SHALL increment every cycle of a burst with no stall condition.
REQ-023 data_out SHALL be the buffer word read one cycle earlier; vld_out SHALL be aligned with it.
REQ-024 Latency: if the final word of an image is accepted in cycle T, no burst is active and the gap is satisfied, vld_out SHALL first be high in cycle T+2 with word 0.
REQ-025 last_out SHALL be high only in the cycle data_out carries word 2^LOG2_IMG_SIZE-1.
REQ-026 After the last read address is issued, that buffer SHALL return to EMPTY on the next edge and rd_sel SHALL toggle.
REQ-027 With GAP=0 and the other buffer FULL, the next burst SHALL follow with zero idle cycles (vld_out continuous across images).
REQ-028 A write to one buffer and a read from the other in the same cycle SHALL both proceed, with no interaction.
REQ-029 The block SHALL never read a FILLING buffer or write a FULL or DRAINING buffer.
REQ-030 Output order SHALL equal accept order; no words are lost or duplicated among accepted words.
REQ-031 When vld_out is low, data_out SHALL hold its previous value and last_out SHALL be 0.

Reset
REQ-032 While rst is high: both buffers EMPTY, wr_sel=rd_sel=0, wr_cntr=0, read idle, gap counter satisfied, vld_out=0, last_out=0, rdy_out=0.
REQ-033 Reset asserted mid-fill or mid-burst SHALL discard all stored and partial images; vld_out SHALL be 0 from the first edge with rst high.
REQ-034 Buffer contents and data_out need no reset; data_out is don't-care while vld_out is 0.
REQ-035 rdy_out SHALL be 1 in the first cycle after rst deasserts.

Verification (NO_CH=2, THROUGHPUT=2, LOG2_IMG_SIZE=3, 8-word images)
REQ-036 Contiguous fill: words 0..7 accepted in cycles 0..7 -> vld_out high cycles 9..16 with words 0..7, last_out only in cycle 16.
REQ-037 Gapped fill: 8 words with vld_in every third cycle, last accepted in cycle 21 -> vld_out high exactly cycles 23..30, data in order.
REQ-038 Backpressure: 24 words offered back-to-back with GAP=0 -> rdy_out low from cycle 16 until the first buffer empties; 24 words output; vld_out continuous across bursts 1 and 2.
REQ-039 GAP=2 with both buffers FULL -> exactly 2 idle cycles between last_out of burst 1 and word 0 of burst 2.
REQ-040 Reset mid-burst: rst high at output word 4 -> vld_out 0 next cycle, no further output until a new full image is accepted, rdy_out=1 after release.
REQ-041 Partial image: 5 words accepted, then idle for 100 cycles -> vld_out stays 0; words 6..8 then produce one burst of the 8 words in order.
